// File: rtl/tile_seq_loader.sv
// Packs a reference and a query character stream into tile-memory words, then holds start until stop.
// Optional macro SEQ_LOADER_ENCODE_EN maps A/C/G/T (any case) to 0..3 and anything else to 4 before packing.
module tile_seq_loader #(
  parameter int DATA_WIDTH        = 8,
  parameter int BLOCK_WIDTH       = 8,
  parameter int MAX_TILE_SIZE     = 1024,
  parameter int LOG_MAX_TILE_SIZE = 10,
  parameter int REF_LEN_WIDTH     = 14,
  parameter int QUERY_LEN_WIDTH   = 14
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_char,
  input  logic                         in_sel,
  input  logic                         in_last,
  output logic                         refWe,
  output logic [LOG_MAX_TILE_SIZE-1:0] refAdr,
  output logic [DATA_WIDTH-1:0]        refData,
  output logic                         queryWe,
  output logic [LOG_MAX_TILE_SIZE-1:0] queryAdr,
  output logic [DATA_WIDTH-1:0]        queryData,
  output logic [REF_LEN_WIDTH-1:0]     refLen,
  output logic [QUERY_LEN_WIDTH-1:0]   queryLen,
  output logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output logic                         overflow,
  output logic [1:0]                   dbg_state
);

  localparam int NUM_BLOCK = DATA_WIDTH / BLOCK_WIDTH;
  localparam int LANE_W    = (NUM_BLOCK > 1) ? $clog2(NUM_BLOCK) : 1;
  localparam int CNT_W     = $clog2(MAX_TILE_SIZE + 1);
  localparam int AW        = LOG_MAX_TILE_SIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Handshake: a beat transfers on a cycle where in_valid && in_ready; in_ready is low only in RUN.

  function automatic logic [BLOCK_WIDTH-1:0] map_char(input logic [7:0] c);
`ifdef SEQ_LOADER_ENCODE_EN
    logic [2:0] k;
    case (c)
      8'h41, 8'h61: k = 3'd0;
      8'h43, 8'h63: k = 3'd1;
      8'h47, 8'h67: k = 3'd2;
      8'h54, 8'h74: k = 3'd3;
      default:      k = 3'd4;
    endcase
    return BLOCK_WIDTH'(k);
`else
    return BLOCK_WIDTH'(c);
`endif
  endfunction

  // Index 0 is the reference packer, index 1 the query packer.
  state_t                      state_q;
  logic [1:0][CNT_W-1:0]       len_q;
  logic [1:0][LANE_W-1:0]      lane_q;
  logic [1:0][AW-1:0]          word_q;
  logic [1:0][DATA_WIDTH-1:0]  buf_q;
  logic [1:0]                  done_q;
  logic [1:0]                  we_q;
  logic [1:0][AW-1:0]          adr_q;
  logic [1:0][DATA_WIDTH-1:0]  data_q;
  logic                        ovf_q;

  logic                        idle, beat, sel, drop, do_wr, go_run;
  logic [BLOCK_WIDTH-1:0]      code;
  logic [CNT_W-1:0]            cur_len, nxt_len;
  logic [LANE_W-1:0]           nxt_lane;
  logic [AW-1:0]               nxt_word;
  logic [DATA_WIDTH-1:0]       placed, nxt_buf, wr_data;
  logic [1:0]                  done_nxt;

  assign idle     = (state_q == S_IDLE);
  assign in_ready = (state_q != S_RUN);
  assign beat     = in_valid && in_ready;
  assign sel      = in_sel;
  assign code     = map_char(in_char);
  // Lengths are held through IDLE for the host, but a new job counts from zero.
  assign cur_len  = idle ? '0 : len_q[sel];

  always_comb begin
    placed   = buf_q[sel];
    placed[int'(lane_q[sel])*BLOCK_WIDTH +: BLOCK_WIDTH] = code;
    nxt_len  = cur_len;
    nxt_lane = lane_q[sel];
    nxt_word = word_q[sel];
    nxt_buf  = buf_q[sel];
    wr_data  = buf_q[sel];
    do_wr    = 1'b0;
    drop     = 1'b0;
    done_nxt = done_q;
    if (done_q[sel]) begin
      drop = 1'b1;
    end else begin
      done_nxt[sel] = in_last;
      if (cur_len == CNT_W'(MAX_TILE_SIZE)) begin
        // Saturated: the character is dropped, but in_last still flushes a partial word.
        drop = 1'b1;
        if (in_last && (lane_q[sel] != '0)) do_wr = 1'b1;
      end else begin
        nxt_len  = cur_len + 1'b1;
        wr_data  = placed;
        nxt_buf  = placed;
        nxt_lane = lane_q[sel] + 1'b1;
        if ((lane_q[sel] == LANE_W'(NUM_BLOCK - 1)) || in_last) do_wr = 1'b1;
      end
      if (do_wr) begin
        nxt_lane = '0;
        nxt_word = word_q[sel] + 1'b1;
        nxt_buf  = '0;
      end
    end
    go_run = &done_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      buf_q   <= '0;
      done_q  <= '0;
      we_q    <= '0;
      adr_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      we_q <= '0;
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (beat) begin
            len_q[sel]  <= nxt_len;
            len_q[!sel] <= idle ? '0 : len_q[!sel];
            lane_q[sel] <= nxt_lane;
            word_q[sel] <= nxt_word;
            buf_q[sel]  <= nxt_buf;
            done_q      <= done_nxt;
            we_q[sel]   <= do_wr;
            if (do_wr) begin
              adr_q[sel]  <= word_q[sel];
              data_q[sel] <= wr_data;
            end
            ovf_q   <= idle ? drop : (ovf_q | drop);
            state_q <= go_run ? S_RUN : S_LOAD;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            word_q  <= '0;
            buf_q   <= '0;
            done_q  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign refWe     = we_q[0];
  assign refAdr    = adr_q[0];
  assign refData   = data_q[0];
  assign queryWe   = we_q[1];
  assign queryAdr  = adr_q[1];
  assign queryData = data_q[1];
  assign refLen    = REF_LEN_WIDTH'(len_q[0]);
  assign queryLen  = QUERY_LEN_WIDTH'(len_q[1]);
  assign start     = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tile_seq_loader.sv
// Bench for tile_seq_loader: directed jobs plus randomized interleaved jobs against a sequence-level model.
module tb_tile_seq_loader;
  localparam int DW = 32, BW = 8, NB = DW / BW, MAX = 16, LW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_sel = 1'b0, in_last = 1'b0, stop = 1'b0;
  logic [7:0]    in_char = 8'h0;
  logic          in_ready, refWe, queryWe, start, busy, overflow;
  logic [LW-1:0] refAdr, queryAdr;
  logic [DW-1:0] refData, queryData;
  logic [13:0]   refLen, queryLen;
  logic [1:0]    dbg_state;

  tile_seq_loader #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .MAX_TILE_SIZE(MAX),
                    .LOG_MAX_TILE_SIZE(LW), .REF_LEN_WIDTH(14), .QUERY_LEN_WIDTH(14)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .in_sel(in_sel), .in_last(in_last), .refWe(refWe), .refAdr(refAdr), .refData(refData),
    .queryWe(queryWe), .queryAdr(queryAdr), .queryData(queryData), .refLen(refLen),
    .queryLen(queryLen), .start(start), .stop(stop), .busy(busy), .overflow(overflow),
    .dbg_state(dbg_state));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [BW-1:0] enc(input logic [7:0] c);
`ifdef SEQ_LOADER_ENCODE_EN
    case (c)
      8'h41, 8'h61: return BW'(0);
      8'h43, 8'h63: return BW'(1);
      8'h47, 8'h67: return BW'(2);
      8'h54, 8'h74: return BW'(3);
      default:      return BW'(4);
    endcase
`else
    return BW'(c);
`endif
  endfunction

  function automatic logic [7:0] rand_char();
    logic [7:0] tbl [10] = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h61, 8'h63, 8'h67, 8'h74, 8'h4e, 8'h78};
    return tbl[$urandom_range(0, 9)];
  endfunction

  int         cnt [2];
  bit         mdone [2];
  bit         movf;
  logic [7:0] acc_ref[$], acc_qry[$];
  logic [7:0] src_ref[$], src_qry[$];

  task automatic model_clear();
    cnt[0] = 0; cnt[1] = 0; mdone[0] = 0; mdone[1] = 0; movf = 0;
    acc_ref = {}; acc_qry = {};
  endtask

  // ---------------- scoreboard of memory writes ----------------
  logic [LW+DW-1:0] ref_got_q[$], qry_got_q[$];
  always @(negedge clk) begin
    if (refWe || queryWe) check("one_we", refWe && queryWe, 1'b0);
    if (refWe)   ref_got_q.push_back({refAdr, refData});
    if (queryWe) qry_got_q.push_back({queryAdr, queryData});
  end

  task automatic compare_seq(input bit sel);
    logic [LW+DW-1:0] exp_q[$];
    logic [DW-1:0]    d;
    int n;
    exp_q = {};
    n = sel ? acc_qry.size() : acc_ref.size();
    for (int w = 0; w * NB < n; w++) begin
      d = '0;
      for (int l = 0; l < NB; l++) begin
        int k = w * NB + l;
        if (k < n) d[l*BW +: BW] = enc(sel ? acc_qry[k] : acc_ref[k]);
      end
      exp_q.push_back({LW'(w), d});
    end
    check(sel ? "qry_nwrites" : "ref_nwrites", sel ? qry_got_q.size() : ref_got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (sel) check("qry_word", (i < qry_got_q.size()) ? qry_got_q[i] : 'x, exp_q[i]);
      else     check("ref_word", (i < ref_got_q.size()) ? ref_got_q[i] : 'x, exp_q[i]);
    end
    if (sel) qry_got_q = {}; else ref_got_q = {};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic sel, input logic [7:0] ch, input logic last);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_sel = sel; in_char = ch; in_last = last;
    check("ready_pre", in_ready, 1'b1);
    check("start_pre", start, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (mdone[sel]) movf = 1;
    else begin
      if (cnt[sel] == MAX) movf = 1;
      else begin
        cnt[sel]++;
        if (sel) acc_qry.push_back(ch); else acc_ref.push_back(ch);
      end
      if (last) mdone[sel] = 1;
    end
    check("refLen", refLen, cnt[0]);
    check("queryLen", queryLen, cnt[1]);
    check("overflow", overflow, movf);
    check("busy", busy, 1'b1);
    check("start", start, mdone[0] && mdone[1]);
    check("in_ready", in_ready, !(mdone[0] && mdone[1]));
  endtask

  // mode 0: random order, 1: all ref first, 2: strict alternation starting with query
  task automatic run_job(input int mode, input int extra);
    int ri = 0, qi = 0, nr, nq;
    logic s, tog;
    bit fin, other;
    tog = 1'b1;
    nr = src_ref.size(); nq = src_qry.size();
    model_clear();
    while (ri < nr || qi < nq) begin
      if (ri >= nr) s = 1'b1;
      else if (qi >= nq) s = 1'b0;
      else if (mode == 0) s = 1'($urandom_range(0, 1));
      else if (mode == 1) s = 1'b0;
      else begin s = tog; tog = ~tog; end
      if (s) begin
        drive_beat(1'b1, src_qry[qi], qi == nq - 1); qi++;
        fin = (qi == nq); other = (ri < nr);
      end else begin
        drive_beat(1'b0, src_ref[ri], ri == nr - 1); ri++;
        fin = (ri == nr); other = (qi < nq);
      end
      if (fin && other) repeat (extra) drive_beat(s, rand_char(), 1'($urandom_range(0, 1)));
    end
    // A beat offered during RUN must not be taken.
    in_valid = 1'b1; in_sel = 1'($urandom_range(0, 1)); in_char = rand_char();
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
      check("run_start", start, 1'b1);
      check("run_ready", in_ready, 1'b0);
      check("run_refLen", refLen, cnt[0]);
    end
    in_valid = 1'b0;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_start", start, 1'b0);
    check("stop_busy", busy, 1'b0);
    check("stop_ready", in_ready, 1'b1);
    check("held_refLen", refLen, cnt[0]);
    check("held_queryLen", queryLen, cnt[1]);
    check("held_overflow", overflow, movf);
    compare_seq(1'b0);
    compare_seq(1'b1);
    // stop outside RUN is ignored
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("idle_stop_busy", busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check("rst_ready", in_ready, 1'b1);
    check("rst_start", start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_we", {refWe, queryWe}, 2'b00);
    check("rst_lens", {refLen, queryLen}, 28'h0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_data", {refAdr, refData, queryAdr, queryData}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // ACGTA / GG, ref first
    src_ref = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h41};
    src_qry = '{8'h47, 8'h47};
`ifndef SEQ_LOADER_ENCODE_EN
    fork
      begin
        logic [LW+DW-1:0] w0;
        wait (ref_got_q.size() > 0 || !rst);
        w0 = ref_got_q[0];
        check("acgta_w0", w0, {LW'(0), 32'h54474341});
      end
    join_none
`endif
    run_job(1, 0);

    // interleaved, query finishes first, one-char query via alternation
    src_ref = '{8'h61, 8'h63, 8'h67, 8'h74, 8'h41, 8'h43};
    src_qry = '{8'h54};
    run_job(2, 2);

    // overflow: 18 ref chars against a 16-char tile
    src_ref = {};
    for (int i = 0; i < 18; i++) src_ref.push_back(rand_char());
    src_qry = '{8'h43, 8'h47, 8'h41};
    run_job(1, 0);
    check("ovf_refLen", refLen, MAX);
    check("ovf_flag", overflow, 1'b1);

    // reset during LOAD after three characters
    model_clear();
    for (int i = 0; i < 3; i++) drive_beat(1'b0, rand_char(), 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_start", start, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_refLen", refLen, 0);
    check("mid_rst_nwrites", ref_got_q.size() + qry_got_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      int nr, nq;
      nr = $urandom_range(1, 20);
      nq = $urandom_range(1, 20);
      src_ref = {}; src_qry = {};
      for (int i = 0; i < nr; i++) src_ref.push_back(rand_char());
      for (int i = 0; i < nq; i++) src_qry.push_back(rand_char());
      run_job($urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tile_seq_loader.md
Name: tile_seq_loader

Overview:
- Streams one reference and one query sequence, character by character, into the aligner's tile memories.
- Packs NUM_BLOCK characters of BLOCK_WIDTH bits into each DATA_WIDTH memory word and tracks refLen/queryLen.
- Once both sequences are complete, holds start to the WFA aligner until stop, then re-arms for the next pair.
- Replaces ad-hoc memory preload: sits between the host/DMA character stream and TALCO_WFAA's ref/query tile RAMs.

Parameters:
- DATA_WIDTH, 8, tile memory word width.
- BLOCK_WIDTH, 8, bits per packed character; NUM_BLOCK = DATA_WIDTH/BLOCK_WIDTH (integer, >=1).
- MAX_TILE_SIZE, 1024, maximum characters per sequence.
- LOG_MAX_TILE_SIZE, 10, memory word address width.
- REF_LEN_WIDTH, 14, refLen width.
- QUERY_LEN_WIDTH, 14, queryLen width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  character beat valid.
- in_ready  out  1  loader accepts the beat.
- in_char  in  8  character (ASCII).
- in_sel  in  1  0 = reference, 1 = query.
- in_last  in  1  final character of the selected sequence.
- refWe  out  1  reference memory write strobe.
- refAdr  out  LOG_MAX_TILE_SIZE  reference word address.
- refData  out  DATA_WIDTH  reference packed word.
- queryWe  out  1  query memory write strobe.
- queryAdr  out  LOG_MAX_TILE_SIZE  query word address.
- queryData  out  DATA_WIDTH  query packed word.
- refLen  out  REF_LEN_WIDTH  accepted reference characters.
- queryLen  out  QUERY_LEN_WIDTH  accepted query characters.
- start  out  1  level; aligner may run.
- stop  in  1  aligner finished.
- busy  out  1  job in progress (not IDLE).
- overflow  out  1  sticky per job; characters dropped.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0 except in_ready=1; packers, lane counters and lengths cleared.
- States:
  - IDLE: the first accepted beat enters LOAD, clears lengths and overflow, and is processed in that same beat.
  - LOAD: remains until both ref_done and qry_done are set, then goes to RUN.
  - RUN: start=1. When stop=1 is sampled, goes to IDLE next cycle with start=0.
- in_ready = 1 in IDLE and LOAD, 0 in RUN. A beat transfers when in_valid && in_ready.
- Packing, per sequence (independent packers):
  - Character n goes to lane n % NUM_BLOCK, bits [lane*BLOCK_WIDTH +: BLOCK_WIDTH], at word n / NUM_BLOCK.
  - Without encoding, the lane takes in_char[BLOCK_WIDTH-1:0], zero-extended when BLOCK_WIDTH > 8.
- Write strobe:
  - Registered: the We pulse, address and data appear one cycle after the beat that fills the last lane or carries in_last.
  - On in_last, unfilled lanes are written as zero.
  - refWe and queryWe may pulse in the same cycle only if they stem from different beats; with one beat per cycle this cannot occur, so at most one strobe per cycle.
- Length:
  - Increments per accepted, non-dropped character and is updated in the same cycle as that beat.
  - refLen/queryLen hold their value after the job until the next job's first beat.
- Overflow:
  - A character beyond MAX_TILE_SIZE is dropped, the length saturates at MAX_TILE_SIZE, and overflow is set.
  - in_last still marks the sequence done and flushes any partial word.
- Beats for an already-done sequence: accepted, discarded, overflow set.
- in_last on a sequence with zero prior characters: length 1, one word written.
- Address wraps never occur; saturation precedes any wrap.
- stop high outside RUN is ignored.
- Reset mid-operation aborts the job immediately; no further strobes.

Optional Feature:
- Macro SEQ_LOADER_ENCODE_EN.
- Defined: in_char is mapped before packing, case-insensitive: A→0, C→1, G→2, T→3, any other→4. The code is zero-extended to BLOCK_WIDTH (requires BLOCK_WIDTH>=3), and the mapping is combinational ahead of the packer, adding no latency.
- Undefined: raw pass-through as above.

Test Plan:
- DATA_WIDTH=32, BLOCK_WIDTH=8; ref "ACGTA" then query "GG", both with last on their final beat → ref words 0x54474341 at addr 0 and 0x00000041 at addr 1; query 0x00004747 at addr 0; refLen=5, queryLen=2; start rises one cycle after the last write-triggering beat and in_ready=0.
- Interleaved ref/query beats, query finishing first → each packer independent; start only after ref in_last; stop pulse → start=0 and busy=0 next cycle; refLen/queryLen held.
- MAX_TILE_SIZE=8: 10 ref chars, last on the 10th → refLen=8, overflow=1, exactly 8 chars written, sequence done.
- rst pulled low during LOAD after 3 chars → immediately in_ready=1 and start=0; next job starts at addr 0 with lengths from 0.
- SEQ_LOADER_ENCODE_EN, BLOCK_WIDTH=4, DATA_WIDTH=8: ref "acgN" → words 0x10 and 0x42.
- Beat to a done sequence while the other is still loading → discarded, overflow=1, no strobe.
